// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// and freeze sequencing around the multi-cycle mul/div unit in EX.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_Rd_i,
    input  logic             EX_muldiv_i,
    input  logic             branch_taken_i,
    input  logic             md_done_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_write_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_bubble_o,
    output logic             md_start_o,
    output logic             md_error_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TMO_W = $clog2(MD_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;
    logic [CNT_W-1:0]   r_stallCnt;
    logic               w_loadUse;
    logic               w_tmoHit;
    logic               w_launch;
    logic               w_setErr;

    assign w_loadUse = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                       ((EX_Rd_i == ID_rs1_i) || (EX_Rd_i == ID_rs2_i));
    assign w_tmoHit  = (r_tmo == TMO_W'(MD_TIMEOUT - 1));

    // MD_DONE shares the RUN hazard logic but never relaunches the instruction still in EX.
    always_comb begin
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_write_o   = 1'b1;
        IDEX_bubble_o  = 1'b0;
        EXMEM_bubble_o = 1'b0;
        md_start_o     = 1'b0;
        w_launch       = 1'b0;
        w_setErr       = 1'b0;
        w_next         = r_state;
        case (r_state)
            MD_BUSY: begin
                PC_write_o     = 1'b0;
                IFID_write_o   = 1'b0;
                IDEX_write_o   = 1'b0;
                EXMEM_bubble_o = 1'b1;
                if (md_done_i) begin
                    w_next = MD_DONE;
                end else if (w_tmoHit) begin
                    w_setErr = 1'b1;
                    w_next   = MD_DONE;
                end
            end
            default: begin
                w_next = RUN;
                if (EX_muldiv_i && (r_state == RUN)) begin
                    w_launch       = 1'b1;
                    md_start_o     = 1'b1;
                    PC_write_o     = 1'b0;
                    IFID_write_o   = 1'b0;
                    IDEX_write_o   = 1'b0;
                    EXMEM_bubble_o = 1'b1;
                    w_next         = MD_BUSY;
                end else if (w_loadUse) begin
                    PC_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                end else if (branch_taken_i) begin
                    IFID_flush_o = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_tmo      <= '0;
            r_err      <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_tmo <= '0;
            end else if (r_state == MD_BUSY) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_setErr) begin
                r_err <= 1'b1;
            end
            // Saturate rather than wrap so long runs never report a small count.
            if (!PC_write_o && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
        end
    end

    assign md_error_o  = r_err;
    assign stall_cnt_o = r_stallCnt;

endmodule
